// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Single-entry register stage between instruction decode and the ALU. An
// accepted instruction is decoded into ALU operands, ALU opcode and
// destination register. All of these are registered and held until the ALU
// side takes them.
//
// Optional feature (compile-time macro ALU_FWD_EN):
//   defined   : MEM/WB results are forwarded onto the register operands at
//               capture time. MEM has priority over WB. $0 is never forwarded.
//   undefined : operands come only from RsData/RtData ($0 still reads 0);
//               the Mem*/Wb* inputs are ignored.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_valid / in_ready                decode-side handshake
//   Opcode, Funct, Rs, Rt, Rd          instruction fields
//   RsData, RtData, Imm16              register-file data, raw immediate
//   MemRegWrite/MemWriteReg/MemResult  MEM-stage writeback (forwarding)
//   WbRegWrite/WbWriteReg/WbResult     WB-stage writeback (forwarding)
//   flush                              kill the held/incoming instruction
//   out_valid / out_ready              ALU-side handshake
//   scrA, scrB, ALUControl, WriteReg   registered ALU operands / control
//   Illegal                            held instruction is undecodable
//   IssueCount                         wrapping count of accepted instructions
// ---------------------------------------------------------------------------
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic [15:0] Imm16,
  input  logic        MemRegWrite,
  input  logic [4:0]  MemWriteReg,
  input  logic [31:0] MemResult,
  input  logic        WbRegWrite,
  input  logic [4:0]  WbWriteReg,
  input  logic [31:0] WbResult,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] scrA,
  output logic [31:0] scrB,
  output logic [3:0]  ALUControl,
  output logic [4:0]  WriteReg,
  output logic        Illegal,
  output logic [15:0] IssueCount
);

  logic        out_valid_reg;
  logic [31:0] scr_a_reg, scr_b_reg;
  logic [3:0]  alu_ctrl_reg;
  logic [4:0]  write_reg_reg;
  logic        illegal_reg;
  logic [15:0] issue_count_reg;

  logic [31:0] scr_a_next, scr_b_next;
  logic [3:0]  alu_ctrl_next;
  logic [4:0]  write_reg_next;
  logic        illegal_next;

  logic        capture;

  // Operand sources: index 0 is Rs, index 1 is Rt.
  logic [1:0][4:0]  src_addr;
  logic [1:0][31:0] src_rf;
  logic [1:0][31:0] src_val;

  assign src_addr = {Rt, Rs};
  assign src_rf   = {RtData, RsData};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
`ifdef ALU_FWD_EN
      // $0 check comes first so a writeback targeting $0 can never leak in;
      // MEM is the younger result, so it is checked before WB.
      assign src_val[gi] =
        (src_addr[gi] == 5'd0)                          ? 32'd0     :
        (MemRegWrite && (MemWriteReg == src_addr[gi]))  ? MemResult :
        (WbRegWrite  && (WbWriteReg  == src_addr[gi]))  ? WbResult  :
                                                          src_rf[gi];
`else
      assign src_val[gi] = (src_addr[gi] == 5'd0) ? 32'd0 : src_rf[gi];
`endif
    end
  endgenerate

`ifndef ALU_FWD_EN
  // Forwarding inputs are intentionally unused in this build.
  logic unused_fwd;
  assign unused_fwd = ^{MemRegWrite, MemWriteReg, MemResult,
                        WbRegWrite, WbWriteReg, WbResult};
`endif

  // Decode. Illegal encodings fall through to a single override at the end
  // so every illegal case produces identical, harmless operands.
  always_comb begin
    illegal_next   = 1'b0;
    alu_ctrl_next  = 4'b0010;
    scr_a_next     = src_val[0];
    scr_b_next     = src_val[1];
    write_reg_next = 5'd0;
    case (Opcode)
      6'h00: begin
        write_reg_next = Rd;
        case (Funct)
          6'h20:   alu_ctrl_next = 4'b0010;
          6'h22:   alu_ctrl_next = 4'b0110;
          6'h24:   alu_ctrl_next = 4'b0000;
          6'h25:   alu_ctrl_next = 4'b0001;
          6'h27:   alu_ctrl_next = 4'b1100;
          6'h2A:   alu_ctrl_next = 4'b0111;
          default: illegal_next  = 1'b1;
        endcase
      end
      6'h08: begin
        alu_ctrl_next  = 4'b0010;
        scr_b_next     = {{16{Imm16[15]}}, Imm16};
        write_reg_next = Rt;
      end
      6'h0A: begin
        alu_ctrl_next  = 4'b0111;
        scr_b_next     = {{16{Imm16[15]}}, Imm16};
        write_reg_next = Rt;
      end
      6'h23: begin
        alu_ctrl_next  = 4'b0010;
        scr_b_next     = {{16{Imm16[15]}}, Imm16};
        write_reg_next = Rt;
      end
      6'h2B: begin
        // Store computes an address only; nothing is written back.
        alu_ctrl_next  = 4'b0010;
        scr_b_next     = {{16{Imm16[15]}}, Imm16};
        write_reg_next = 5'd0;
      end
      6'h0C: begin
        alu_ctrl_next  = 4'b0000;
        scr_b_next     = {16'd0, Imm16};
        write_reg_next = Rt;
      end
      6'h0D: begin
        alu_ctrl_next  = 4'b0001;
        scr_b_next     = {16'd0, Imm16};
        write_reg_next = Rt;
      end
      6'h04: begin
        // Branch compares by subtraction of the two register operands.
        alu_ctrl_next  = 4'b0110;
        write_reg_next = 5'd0;
      end
      default: illegal_next = 1'b1;
    endcase
    if (illegal_next) begin
      alu_ctrl_next  = 4'b0010;
      scr_a_next     = 32'd0;
      scr_b_next     = 32'd0;
      write_reg_next = 5'd0;
    end
  end

  assign in_ready = !out_valid_reg || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg   <= 1'b0;
      scr_a_reg       <= 32'd0;
      scr_b_reg       <= 32'd0;
      alu_ctrl_reg    <= 4'b0000;
      write_reg_reg   <= 5'd0;
      illegal_reg     <= 1'b0;
      issue_count_reg <= 16'd0;
    end else if (flush) begin
      // Flush wins over any same-cycle capture; payload registers keep
      // their stale contents, which is harmless once out_valid is low.
      out_valid_reg <= 1'b0;
    end else if (capture) begin
      out_valid_reg   <= 1'b1;
      scr_a_reg       <= scr_a_next;
      scr_b_reg       <= scr_b_next;
      alu_ctrl_reg    <= alu_ctrl_next;
      write_reg_reg   <= write_reg_next;
      illegal_reg     <= illegal_next;
      issue_count_reg <= issue_count_reg + 16'd1;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid  = out_valid_reg;
  assign scrA       = scr_a_reg;
  assign scrB       = scr_b_reg;
  assign ALUControl = alu_ctrl_reg;
  assign WriteReg   = write_reg_reg;
  assign Illegal    = illegal_reg;
  assign IssueCount = issue_count_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed testbench for alu_issue_stage. Expected values are hand-derived
// from the decode table. Forwarding expectations follow the ALU_FWD_EN macro
// used for the build.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

`ifdef ALU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  Opcode, Funct;
  logic [4:0]  Rs, Rt, Rd;
  logic [31:0] RsData, RtData;
  logic [15:0] Imm16;
  logic        MemRegWrite;
  logic [4:0]  MemWriteReg;
  logic [31:0] MemResult;
  logic        WbRegWrite;
  logic [4:0]  WbWriteReg;
  logic [31:0] WbResult;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] scrA, scrB;
  logic [3:0]  ALUControl;
  logic [4:0]  WriteReg;
  logic        Illegal;
  logic [15:0] IssueCount;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  logic [74:0] obs;
  assign obs = {out_valid, Illegal, ALUControl, WriteReg, scrA, scrB};

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Opcode(Opcode), .Funct(Funct), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .RsData(RsData), .RtData(RtData), .Imm16(Imm16),
    .MemRegWrite(MemRegWrite), .MemWriteReg(MemWriteReg), .MemResult(MemResult),
    .WbRegWrite(WbRegWrite), .WbWriteReg(WbWriteReg), .WbResult(WbResult),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .scrA(scrA), .scrB(scrB), .ALUControl(ALUControl), .WriteReg(WriteReg),
    .Illegal(Illegal), .IssueCount(IssueCount)
  );

  function automatic logic [74:0] ex(input logic v, input logic il,
                                     input logic [3:0] alu, input logic [4:0] wr,
                                     input logic [31:0] a, input logic [31:0] b);
    return {v, il, alu, wr, a, b};
  endfunction

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] rsd,
                           input logic [31:0] rtd, input logic [15:0] imm);
    Opcode = op; Funct = fn; Rs = rs; Rt = rt; Rd = rd;
    RsData = rsd; RtData = rtd; Imm16 = imm;
  endtask

  task automatic clear_fwd;
    MemRegWrite = 1'b0; MemWriteReg = 5'd0; MemResult = 32'd0;
    WbRegWrite  = 1'b0; WbWriteReg  = 5'd0; WbResult  = 32'd0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0);
    clear_fwd();
    #2;
    checks++;
    if (obs !== 75'd0 || IssueCount !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got %h/%h required 0/0", obs, IssueCount);
    end else $display("reset_state ok");
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end else $display("reset_in_ready ok");
    #20 rst_n = 1'b1;
    step();
  endtask

  task automatic test_add;
    set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    step(); exp_count++;
    in_valid = 1'b0;
    checks++;
    if (obs !== ex(1'b1, 1'b0, 4'b0010, 5'd3, 32'd5, 32'd7)) begin
      errors++;
      $display("FAIL add: got %h required %h", obs, ex(1'b1, 1'b0, 4'b0010, 5'd3, 32'd5, 32'd7));
    end else $display("add ok");
    checks++;
    if (IssueCount !== 16'(exp_count)) begin
      errors++;
      $display("FAIL add_count: got %0d required %0d", IssueCount, exp_count);
    end else $display("add_count ok");
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_transfer: out_valid got %b required 0", out_valid);
    end else $display("add_transfer ok");
  endtask

  task automatic test_rtype;
    logic [5:0] fn [6];
    logic [3:0] alu [6];
    fn  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    alu = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_instr(6'h00, fn[i], 5'd6, 5'd7, 5'd8, 32'h100 + i, 32'h200 + i, 16'd0);
      step(); exp_count++;
      checks++;
      if (obs !== ex(1'b1, 1'b0, alu[i], 5'd8, 32'h100 + i, 32'h200 + i)) begin
        errors++;
        $display("FAIL rtype_funct_%h: got %h required %h", fn[i], obs,
                 ex(1'b1, 1'b0, alu[i], 5'd8, 32'h100 + i, 32'h200 + i));
      end else $display("rtype funct %h ok", fn[i]);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_itypes;
    logic [5:0]  op   [7];
    logic [15:0] imm  [7];
    logic [31:0] eb   [7];
    logic [3:0]  alu  [7];
    logic [4:0]  wr   [7];
    op  = '{6'h0D, 6'h08, 6'h0C, 6'h0A, 6'h23, 6'h2B, 6'h04};
    imm = '{16'h8001, 16'h8001, 16'hF0F0, 16'hFFFE, 16'h0004, 16'h8000, 16'h1234};
    eb  = '{32'h00008001, 32'hFFFF8001, 32'h0000F0F0, 32'hFFFFFFFE,
            32'h00000004, 32'hFFFF8000, 32'h00000055};
    alu = '{4'b0001, 4'b0010, 4'b0000, 4'b0111, 4'b0010, 4'b0010, 4'b0110};
    wr  = '{5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd0, 5'd0};
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_instr(op[i], 6'h3F, 5'd2, 5'd9, 5'd12, 32'h10, 32'h55, imm[i]);
      step(); exp_count++;
      checks++;
      if (obs !== ex(1'b1, 1'b0, alu[i], wr[i], 32'h10, eb[i])) begin
        errors++;
        $display("FAIL itype_op_%h: got %h required %h", op[i], obs,
                 ex(1'b1, 1'b0, alu[i], wr[i], 32'h10, eb[i]));
      end else $display("itype op %h ok", op[i]);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_zero_reg;
    set_instr(6'h00, 6'h20, 5'd0, 5'd0, 5'd3, 32'h1234, 32'h5678, 16'd0);
    MemRegWrite = 1'b1; MemWriteReg = 5'd0; MemResult = 32'h99;
    WbRegWrite  = 1'b1; WbWriteReg  = 5'd0; WbResult  = 32'h77;
    in_valid = 1'b1; out_ready = 1'b1;
    step(); exp_count++;
    in_valid = 1'b0;
    clear_fwd();
    checks++;
    if (obs !== ex(1'b1, 1'b0, 4'b0010, 5'd3, 32'd0, 32'd0)) begin
      errors++;
      $display("FAIL zero_reg: got %h required %h", obs, ex(1'b1, 1'b0, 4'b0010, 5'd3, 32'd0, 32'd0));
    end else $display("zero_reg ok");
    step();
  endtask

  task automatic test_forwarding;
    logic [31:0] ea, eb;
    in_valid = 1'b1; out_ready = 1'b1;
    // Both stages match Rs: MEM wins.
    set_instr(6'h00, 6'h22, 5'd4, 5'd5, 5'd6, 32'h11, 32'h22, 16'd0);
    MemRegWrite = 1'b1; MemWriteReg = 5'd4; MemResult = 32'hAA;
    WbRegWrite  = 1'b1; WbWriteReg  = 5'd4; WbResult  = 32'hBB;
    step(); exp_count++;
    ea = FWD ? 32'hAA : 32'h11;
    checks++;
    if (obs !== ex(1'b1, 1'b0, 4'b0110, 5'd6, ea, 32'h22)) begin
      errors++;
      $display("FAIL fwd_mem_wins: got %h required %h", obs, ex(1'b1, 1'b0, 4'b0110, 5'd6, ea, 32'h22));
    end else $display("fwd_mem_wins ok");
    // Only WB matches Rs.
    MemRegWrite = 1'b0;
    step(); exp_count++;
    ea = FWD ? 32'hBB : 32'h11;
    checks++;
    if (scrA !== ea) begin
      errors++;
      $display("FAIL fwd_wb: scrA got %h required %h", scrA, ea);
    end else $display("fwd_wb ok");
    // Both target Rt.
    MemRegWrite = 1'b1; MemWriteReg = 5'd5; WbWriteReg = 5'd5;
    step(); exp_count++;
    eb = FWD ? 32'hAA : 32'h22;
    checks++;
    if (scrA !== 32'h11 || scrB !== eb) begin
      errors++;
      $display("FAIL fwd_rt: got %h/%h required 00000011/%h", scrA, scrB, eb);
    end else $display("fwd_rt ok");
    // Rs=$0 with a writeback to $0 pending.
    Rs = 5'd0; MemWriteReg = 5'd0; WbWriteReg = 5'd0;
    step(); exp_count++;
    checks++;
    if (scrA !== 32'd0) begin
      errors++;
      $display("FAIL fwd_rs_zero: scrA got %h required 0", scrA);
    end else $display("fwd_rs_zero ok");
    in_valid = 1'b0;
    clear_fwd();
    step();
  endtask

  task automatic test_back_to_back;
    set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h11, 32'd7, 16'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    step(); exp_count++;
    set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h22, 32'd7, 16'd0);
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_in_ready: got %b required 0", in_ready);
    end else $display("stall_in_ready ok");
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== ex(1'b1, 1'b0, 4'b0010, 5'd3, 32'h11, 32'd7) ||
          IssueCount !== 16'(exp_count) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %h cnt %0d rdy %b required %h cnt %0d rdy 0", i, obs,
                 IssueCount, in_ready, ex(1'b1, 1'b0, 4'b0010, 5'd3, 32'h11, 32'd7), exp_count);
      end else $display("stall cycle %0d ok", i);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready: got %b required 1", in_ready);
    end else $display("release_in_ready ok");
    step(); exp_count++;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || scrA !== 32'h22 || IssueCount !== 16'(exp_count)) begin
      errors++;
      $display("FAIL release_capture: got v%b %h cnt %0d required v1 00000022 cnt %0d",
               out_valid, scrA, IssueCount, exp_count);
    end else $display("release_capture ok");
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_drain: out_valid got %b required 0", out_valid);
    end else $display("release_drain ok");
  endtask

  task automatic test_flush_illegal;
    // Flush together with an incoming instruction.
    set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'd0);
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || IssueCount !== 16'(exp_count)) begin
      errors++;
      $display("FAIL flush_capture: got v%b cnt %0d required v0 cnt %0d", out_valid, IssueCount, exp_count);
    end else $display("flush_capture ok");
    // Flush a held, stalled instruction.
    in_valid = 1'b1; out_ready = 1'b0;
    step(); exp_count++;
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || IssueCount !== 16'(exp_count)) begin
      errors++;
      $display("FAIL flush_held: got v%b cnt %0d required v0 cnt %0d", out_valid, IssueCount, exp_count);
    end else $display("flush_held ok");
    // Illegal opcode.
    set_instr(6'h3F, 6'h20, 5'd1, 5'd2, 5'd3, 32'hDEAD, 32'hBEEF, 16'h1234);
    in_valid = 1'b1;
    step(); exp_count++;
    checks++;
    if (obs !== ex(1'b1, 1'b1, 4'b0010, 5'd0, 32'd0, 32'd0) || IssueCount !== 16'(exp_count)) begin
      errors++;
      $display("FAIL illegal_opcode: got %h cnt %0d required %h cnt %0d", obs, IssueCount,
               ex(1'b1, 1'b1, 4'b0010, 5'd0, 32'd0, 32'd0), exp_count);
    end else $display("illegal_opcode ok");
    // Illegal R-type funct.
    set_instr(6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 32'hDEAD, 32'hBEEF, 16'd0);
    step(); exp_count++;
    checks++;
    if (obs !== ex(1'b1, 1'b1, 4'b0010, 5'd0, 32'd0, 32'd0)) begin
      errors++;
      $display("FAIL illegal_funct: got %h required %h", obs, ex(1'b1, 1'b1, 4'b0010, 5'd0, 32'd0, 32'd0));
    end else $display("illegal_funct ok");
    // Legal instruction right after clears Illegal.
    set_instr(6'h00, 6'h25, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 16'd0);
    step(); exp_count++;
    in_valid = 1'b0;
    checks++;
    if (obs !== ex(1'b1, 1'b0, 4'b0001, 5'd3, 32'h5, 32'h6)) begin
      errors++;
      $display("FAIL illegal_clear: got %h required %h", obs, ex(1'b1, 1'b0, 4'b0001, 5'd3, 32'h5, 32'h6));
    end else $display("illegal_clear ok");
    step();
  endtask

  task automatic test_async_reset;
    set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h33, 32'h44, 16'd0);
    in_valid = 1'b1; out_ready = 1'b0;
    step(); exp_count++;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 75'd0 || IssueCount !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got %h cnt %0d required 0 cnt 0", obs, IssueCount);
    end else $display("async_reset ok");
    step();
    checks++;
    if (obs !== 75'd0 || IssueCount !== 16'd0) begin
      errors++;
      $display("FAIL reset_no_capture: got %h cnt %0d required 0 cnt 0", obs, IssueCount);
    end else $display("reset_no_capture ok");
    #2 rst_n = 1'b1;
    exp_count = 0;
    step(); exp_count++;
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (obs !== ex(1'b1, 1'b0, 4'b0010, 5'd3, 32'h33, 32'h44) || IssueCount !== 16'(exp_count)) begin
      errors++;
      $display("FAIL first_capture: got %h cnt %0d required %h cnt %0d", obs, IssueCount,
               ex(1'b1, 1'b0, 4'b0010, 5'd3, 32'h33, 32'h44), exp_count);
    end else $display("first_capture ok");
    step();
  endtask

  task automatic test_count_wrap;
    int n;
    set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, 16'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    n = 16'hFFFF - exp_count;
    repeat (n) @(posedge clk);
    #1;
    exp_count = 16'hFFFF;
    checks++;
    if (IssueCount !== 16'hFFFF) begin
      errors++;
      $display("FAIL count_max: got %h required ffff", IssueCount);
    end else $display("count_max ok");
    step();
    in_valid = 1'b0;
    checks++;
    if (IssueCount !== 16'h0000) begin
      errors++;
      $display("FAIL count_wrap: got %h required 0000", IssueCount);
    end else $display("count_wrap ok");
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_rtype();
    test_itypes();
    test_zero_reg();
    test_forwarding();
    test_back_to_back();
    test_flush_illegal();
    test_async_reset();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
